// File: rtl/wb_dsp_bus_master_pkg.sv
// Shared encodings for the DSP Wishbone bus master.
// FSM states, completion status codes and classic-cycle tags.
package wb_dsp_bus_master_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACCESS  = 2'b01,
    S_BACKOFF = 2'b10
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_RTY_EXH = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_dsp_bus_master.sv
// Wishbone B3 classic single-access master for the DSP core.
// One command in flight; handles ack/err/rty, retry backoff and timeout.
module wb_dsp_bus_master
  import wb_dsp_bus_master_pkg::*;
#(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int TIMEOUT   = 255,
  parameter int RETRY_MAX = 3,
  parameter int BACKOFF   = 2
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic          cmd_start,
  input  logic [aw-1:0] cmd_adr,
  input  logic [dw-1:0] cmd_dat,
  input  logic [3:0]    cmd_sel,
  input  logic          cmd_we,
  output logic          cmd_busy,
  output logic          cmd_done,
  output logic [1:0]    cmd_status,
  output logic [dw-1:0] cmd_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] RTY_MAX  = 4'(RETRY_MAX);
  localparam logic [3:0] BO_LAST  = 4'(BACKOFF - 1);

  state_t state, state_n;

  logic [aw-1:0] adr_q;
  logic [dw-1:0] dat_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic [3:0]    rty_cnt, rty_cnt_n;
  logic [7:0]    tmo_cnt, tmo_cnt_n;
  logic [3:0]    bo_cnt, bo_cnt_n;
  logic          done_q, done_n;
  logic [1:0]    status_q, status_n;
  logic [dw-1:0] rdata_q, rdata_n;
  logic          latch;
  logic          access;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state    <= S_IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rty_cnt  <= '0;
      tmo_cnt  <= '0;
      bo_cnt   <= '0;
      done_q   <= 1'b0;
      status_q <= ST_OK;
      rdata_q  <= '0;
    end else begin
      state    <= state_n;
      rty_cnt  <= rty_cnt_n;
      tmo_cnt  <= tmo_cnt_n;
      bo_cnt   <= bo_cnt_n;
      done_q   <= done_n;
      status_q <= status_n;
      rdata_q  <= rdata_n;
      if (latch) begin
        adr_q <= cmd_adr;
        dat_q <= cmd_dat;
        sel_q <= cmd_sel;
        we_q  <= cmd_we;
      end
    end
  end

  always_comb begin
    state_n   = state;
    rty_cnt_n = rty_cnt;
    tmo_cnt_n = tmo_cnt;
    bo_cnt_n  = bo_cnt;
    done_n    = 1'b0;
    status_n  = status_q;
    rdata_n   = rdata_q;
    latch     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_start) begin
          latch     = 1'b1;
          rty_cnt_n = '0;
          tmo_cnt_n = '0;
          state_n   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Terminations resolve in fixed priority: err, ack, rty, timeout.
        if (wb_err_i) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          status_n = ST_BUS_ERR;
        end else if (wb_ack_i) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          status_n = ST_OK;
          if (!we_q) rdata_n = wb_dat_i;
        end else if (wb_rty_i) begin
          if (rty_cnt < RTY_MAX) begin
            rty_cnt_n = rty_cnt + 4'd1;
            bo_cnt_n  = '0;
            state_n   = S_BACKOFF;
          end else begin
            state_n  = S_IDLE;
            done_n   = 1'b1;
            status_n = ST_RTY_EXH;
          end
        end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
          state_n  = S_IDLE;
          done_n   = 1'b1;
          status_n = ST_TIMEOUT;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
      end
      S_BACKOFF: begin
        if (bo_cnt == BO_LAST) begin
          tmo_cnt_n = '0;
          state_n   = S_ACCESS;
        end else begin
          bo_cnt_n = bo_cnt + 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign access     = (state == S_ACCESS);
  assign wb_cyc_o   = access;
  assign wb_stb_o   = access;
  assign wb_we_o    = access & we_q;
  assign wb_adr_o   = access ? adr_q : '0;
  assign wb_dat_o   = access ? dat_q : '0;
  assign wb_sel_o   = access ? sel_q : '0;
  assign wb_cti_o   = CTI_CLASSIC;
  assign wb_bte_o   = BTE_LINEAR;
  assign cmd_busy   = (state != S_IDLE);
  assign cmd_done   = done_q;
  assign cmd_status = status_q;
  assign cmd_rdata  = rdata_q;

endmodule

// File: tb/tb_wb_dsp_bus_master.sv
// Directed self-checking bench for wb_dsp_bus_master.
// Second instance with TIMEOUT=0 covers the no-timeout hold.
module tb_wb_dsp_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic        start = 1'b0;
  logic [31:0] c_adr = '0, c_dat = '0;
  logic [3:0]  c_sel = '0;
  logic        c_we = 1'b0;

  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        busy, done;
  logic [1:0]  status;
  logic [31:0] rdata;

  logic        rst0 = 1'b1;
  logic        start0 = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] adr0, dat0, rdata0;
  logic [3:0]  sel0;
  logic        we0, cyc0, stb0, busy0, done0;
  logic [2:0]  cti0;
  logic [1:0]  bte0, status0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_dsp_bus_master #(
    .dw(32), .aw(32), .TIMEOUT(8), .RETRY_MAX(3), .BACKOFF(2)
  ) dut (
    .wb_clk(clk), .wb_rst(rst),
    .wb_adr_o(adr_o), .wb_dat_o(dat_o), .wb_sel_o(sel_o),
    .wb_we_o(we_o), .wb_cyc_o(cyc_o), .wb_stb_o(stb_o),
    .wb_cti_o(cti_o), .wb_bte_o(bte_o),
    .wb_dat_i(dat_i), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
    .cmd_start(start), .cmd_adr(c_adr), .cmd_dat(c_dat),
    .cmd_sel(c_sel), .cmd_we(c_we),
    .cmd_busy(busy), .cmd_done(done),
    .cmd_status(status), .cmd_rdata(rdata)
  );

  wb_dsp_bus_master #(
    .dw(32), .aw(32), .TIMEOUT(0), .RETRY_MAX(3), .BACKOFF(2)
  ) dut0 (
    .wb_clk(clk), .wb_rst(rst0),
    .wb_adr_o(adr0), .wb_dat_o(dat0), .wb_sel_o(sel0),
    .wb_we_o(we0), .wb_cyc_o(cyc0), .wb_stb_o(stb0),
    .wb_cti_o(cti0), .wb_bte_o(bte0),
    .wb_dat_i(32'h0), .wb_ack_i(zero), .wb_err_i(zero), .wb_rty_i(zero),
    .cmd_start(start0), .cmd_adr(32'h100), .cmd_dat(32'h0),
    .cmd_sel(4'hF), .cmd_we(zero),
    .cmd_busy(busy0), .cmd_done(done0),
    .cmd_status(status0), .cmd_rdata(rdata0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w);
    start = 1'b1;
    c_adr = a;
    c_dat = d;
    c_sel = s;
    c_we  = w;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    int att;
    logic prev;
    logic held;

    tick();
    tick();
    rst  = 1'b0;
    rst0 = 1'b0;
    chk("rst_cyc", 64'(cyc_o), 64'd0);
    chk("rst_stb", 64'(stb_o), 64'd0);
    chk("rst_adr", 64'(adr_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_cti", 64'(cti_o), 64'd0);
    chk("rst_bte", 64'(bte_o), 64'd0);

    // registered-ack read
    issue(32'h10, 32'h0, 4'hF, 1'b0);
    chk("rd_cyc0", 64'(cyc_o), 64'd1);
    chk("rd_stb0", 64'(stb_o), 64'd1);
    chk("rd_adr", 64'(adr_o), 64'h10);
    chk("rd_we", 64'(we_o), 64'd0);
    chk("rd_busy", 64'(busy), 64'd1);
    tick();
    chk("rd_cyc1", 64'(cyc_o), 64'd1);
    ack   = 1'b1;
    dat_i = 32'hDEADBEEF;
    tick();
    chk("rd_cyc_drop", 64'(cyc_o), 64'd0);
    chk("rd_done", 64'(done), 64'd1);
    chk("rd_busy_done", 64'(busy), 64'd0);
    chk("rd_status", 64'(status), 64'd0);
    chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
    tick();
    ack = 1'b0;
    chk("rd_trail_done", 64'(done), 64'd0);
    chk("rd_trail_cyc", 64'(cyc_o), 64'd0);
    chk("rd_trail_busy", 64'(busy), 64'd0);

    // write; read data bus carries junk that must not land in rdata
    dat_i = 32'hCAFEF00D;
    issue(32'h04, 32'h12345678, 4'b0011, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("wr_adr", 64'(adr_o), 64'h04);
      chk("wr_dat", 64'(dat_o), 64'h12345678);
      chk("wr_sel", 64'(sel_o), 64'h3);
      chk("wr_we", 64'(we_o), 64'd1);
      if (i == 2) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    chk("wr_done", 64'(done), 64'd1);
    chk("wr_status", 64'(status), 64'd0);
    chk("wr_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("wr_cyc", 64'(cyc_o), 64'd0);
    tick();

    // two rty then ack
    issue(32'h80, 32'h0, 4'hF, 1'b0);
    for (int r = 0; r < 2; r++) begin
      chk("rty_cyc_acc", 64'(cyc_o), 64'd1);
      chk("rty_adr", 64'(adr_o), 64'h80);
      rty = 1'b1;
      tick();
      rty = 1'b0;
      chk("rty_bo1", 64'(cyc_o), 64'd0);
      chk("rty_bo1_busy", 64'(busy), 64'd1);
      tick();
      chk("rty_bo2", 64'(cyc_o), 64'd0);
      chk("rty_bo2_done", 64'(done), 64'd0);
      tick();
    end
    chk("rty_cyc3", 64'(cyc_o), 64'd1);
    ack   = 1'b1;
    dat_i = 32'hA5A50001;
    tick();
    ack = 1'b0;
    chk("rty_done", 64'(done), 64'd1);
    chk("rty_status", 64'(status), 64'd0);
    chk("rty_rdata", 64'(rdata), 64'hA5A50001);
    tick();

    // rty forever: four attempts then exhausted
    rty = 1'b1;
    issue(32'h84, 32'h0, 4'hF, 1'b0);
    att  = (cyc_o === 1'b1) ? 1 : 0;
    prev = cyc_o;
    n    = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      if (cyc_o === 1'b1 && prev !== 1'b1) att++;
      prev = cyc_o;
      n++;
    end
    rty = 1'b0;
    chk("rtyx_attempts", 64'(att), 64'd4);
    chk("rtyx_done", 64'(done), 64'd1);
    chk("rtyx_status", 64'(status), 64'h2);
    chk("rtyx_edges", 64'(n), 64'd10);
    tick();

    // silent slave, TIMEOUT=8
    issue(32'h88, 32'h0, 4'hF, 1'b0);
    n = 0;
    while (cyc_o === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 64'(n), 64'd8);
    chk("tmo_done", 64'(done), 64'd1);
    chk("tmo_status", 64'(status), 64'h3);
    tick();

    // TIMEOUT=0 holds the bus
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (cyc0 !== 1'b1 || stb0 !== 1'b1 || done0 !== 1'b0) held = 1'b0;
      tick();
    end
    chk("notmo_held", 64'(held), 64'd1);
    chk("notmo_busy", 64'(busy0), 64'd1);
    chk("notmo_adr", 64'(adr0), 64'h100);

    // err with ack
    issue(32'h8C, 32'h0, 4'hF, 1'b0);
    err   = 1'b1;
    ack   = 1'b1;
    dat_i = 32'h77777777;
    tick();
    err = 1'b0;
    ack = 1'b0;
    chk("err_done", 64'(done), 64'd1);
    chk("err_status", 64'(status), 64'h1);
    chk("err_rdata", 64'(rdata), 64'hA5A50001);
    tick();

    // start while busy ignored; start during done accepted next edge
    issue(32'h20, 32'h0, 4'hF, 1'b0);
    start = 1'b1;
    c_adr = 32'h44;
    tick();
    start = 1'b0;
    chk("busy_adr", 64'(adr_o), 64'h20);
    ack   = 1'b1;
    dat_i = 32'h11112222;
    tick();
    ack = 1'b0;
    chk("busy_done", 64'(done), 64'd1);
    chk("busy_rdata", 64'(rdata), 64'h11112222);
    start = 1'b1;
    c_adr = 32'h30;
    tick();
    start = 1'b0;
    chk("b2b_cyc", 64'(cyc_o), 64'd1);
    chk("b2b_adr", 64'(adr_o), 64'h30);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("b2b_done", 64'(done), 64'd1);
    tick();
    chk("b2b_idle", 64'(cyc_o), 64'd0);

    // reset mid-ACCESS
    issue(32'h50, 32'h0, 4'hF, 1'b0);
    chk("mrst_cyc_pre", 64'(cyc_o), 64'd1);
    rst = 1'b1;
    tick();
    chk("mrst_cyc", 64'(cyc_o), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    tick();
    chk("mrst_done2", 64'(done), 64'd0);
    chk("mrst_cyc2", 64'(cyc_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
